load_store_unit: RTL and testbench
==================================

# load_store_unit

Processor-side initiator for the word-organised data memory. Accepts one load or store request at a time from the execute stage: RV32I byte address, funct3 width code, store data. Drives the memory's word address, write data and write enable. Loads are sign- or zero-extended. Byte and halfword stores are done as a read-modify-write, because the memory only writes full words. Misaligned, illegal and out-of-range accesses return an error and never touch memory.

## Interface
- MEM_WORDS, 512, data memory depth in 32-bit words; word index ≥ MEM_WORDS is out of range
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  width code: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = misaligned, illegal funct3, or out of range
- rdata  out  32  load result; updated only at a successful load completion
- mem_addr  out  32  word index = {2'b00, addr[31:2]} of latched request
- mem_wd  out  32  write data to memory
- mem_we  out  1  memory write enable
- mem_rd  in  32  combinational read data from memory at mem_addr

## Operation
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- IDLE with req=1: latch we, funct3, addr, wdata. Next state:
  - Error (funct3[1:0]=01 and addr[0]≠0; funct3=010 and addr[1:0]≠0; funct3 ∉ legal set for we; addr[31:2] ≥ MEM_WORDS) → RESP with err.
  - Load → LOAD.
  - SW → WRITE.
  - SB or SH → RMW_RD.
- LOAD: capture mem_rd and select the lane, little-endian.
  - Byte k = bits [8k+7:8k], k = addr[1:0].
  - Half = [15:0] if addr[1]=0, else [31:16].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
  - Result goes to rdata; → RESP.
- WRITE: mem_we=1, mem_wd=wdata → RESP.
- RMW_RD: register mem_rd into the merge register; → RMW_WR.
- RMW_WR: mem_we=1. mem_wd = merge register with the selected byte/half replaced by wdata[7:0]/[15:0]; other lanes unchanged. → RESP.
- RESP: done=1; err as determined; → IDLE.
- req while busy is ignored; a request is accepted only in IDLE.
- mem_we is high only in WRITE and RMW_WR, and is decoded from state (goes low immediately on reset).
- Error responses clear rdata to 0. On err, mem_we is never asserted.

## Timing
- Reset values: state IDLE; busy, done, err, mem_we = 0; rdata, mem_addr, mem_wd, merge register = 0.
- Request sampled at edge E0. Completion pulse (done high) by access type:
  - Load: done during the cycle after E2 (latency 2).
  - SW: memory written at E1; done after E2 (latency 2).
  - SB/SH: read at E1, write at E2; done after E3 (latency 3).
  - Error: done after E1 (latency 1).
- Minimum request spacing: latency + 1 cycles, since the next request is accepted only after returning to IDLE.
- mem_addr is stable from the cycle after E0 until RESP; mem_rd is combinational and sampled at the edge leaving LOAD or RMW_RD.
- Reset asserted mid-operation: return to IDLE at once, and no write occurs at the following edge. For SB/SH reset in RMW_RD, memory is untouched. Reset in RMW_WR before the edge also leaves memory untouched.
- rdata holds its value across stores and idle cycles.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF → mem word 4 = 0xDEADBEEF at E1; done, err=0 after E2; then LW 0x10 → rdata 0xDEADBEEF.
- Word 4 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- Word 4 = 0xDEADBEEF:
  - SB addr 0x11, wdata 0x55 → word 4 = 0xDEAD55EF, mem_we high exactly 1 cycle, done at latency 3.
  - SH addr 0x12, wdata 0x1234 → 0x123455EF.
- Error cases, each → done+err at latency 1, mem_we never high, memory unchanged, rdata 0:
  - LW 0x11
  - SH 0x13
  - funct3=011
  - store funct3=100
  - addr 0x800 (word 512 with MEM_WORDS=512)
- req held high continuously through a load → second request accepted only after IDLE; busy never drops mid-access.
- Assert reset during RMW_RD of SB to 0x10 → busy/done/mem_we 0 immediately, word 4 unchanged; next LW 0x10 returns the original value.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and word-memory bus between the execute stage, the
// load/store unit and the data memory.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    // master: execute stage plus memory model; slave: the load/store unit
    modport master (
        output req, we, funct3, addr, wdata, mem_rd,
        input  busy, done, err, rdata, mem_addr, mem_wd, mem_we
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rd,
        output busy, done, err, rdata, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-organised data memory; sub-word stores
// are performed as read-modify-write, bad accesses are answered with err.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 512
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    state_t      state_reg, state_next;
    logic [2:0]  funct3_reg;
    logic [1:0]  lane_reg;
    logic [31:0] wdata_reg;
    logic [31:0] merge_reg;
    logic [31:0] rdata_reg;
    logic [31:0] mem_addr_reg;
    logic        err_reg;

    logic        legal_f3;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        accept;

    logic [7:0]  lane_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;
    logic [3:0]  byte_en;
    logic [31:0] repl;
    logic [31:0] merged;

    assign accept = (state_reg == IDLE) && bus.req;

    // Request validation on the raw inputs, so the verdict is latched at accept
    always_comb begin
        legal_f3 = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = !bus.we;
            default:                legal_f3 = 1'b0;
        endcase
        misaligned   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                       ((bus.funct3 == 3'b010) && (bus.addr[1:0] != 2'b00));
        out_of_range = {2'b00, bus.addr[31:2]} >= WORD_LIMIT;
        req_err      = !legal_f3 || misaligned || out_of_range;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (req_err)                  state_next = RESP;
                    else if (!bus.we)             state_next = LOAD;
                    else if (bus.funct3 == 3'b010) state_next = WRITE;
                    else                          state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            WRITE:   state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-lane views of the memory word and byte enables for sub-word stores
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = bus.mem_rd[8*gi +: 8];
            assign byte_en[gi]   = funct3_reg[0] ? (lane_reg[1] == 1'(gi / 2))
                                                 : (lane_reg == 2'(gi));
            assign merged[8*gi +: 8] = byte_en[gi] ? repl[8*gi +: 8]
                                                   : merge_reg[8*gi +: 8];
        end
    endgenerate

    // Store data replicated across lanes; byte_en picks which copy lands
    assign repl = funct3_reg[0] ? {wdata_reg[15:0], wdata_reg[15:0]}
                                : {4{wdata_reg[7:0]}};

    assign byte_sel = lane_byte[lane_reg];
    assign half_sel = lane_reg[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    always_comb begin
        load_value = bus.mem_rd;
        case (funct3_reg)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {24'h0, byte_sel};
            3'b101:  load_value = {16'h0, half_sel};
            default: load_value = bus.mem_rd;
        endcase
    end

    // Request latch, load result and read-modify-write merge register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_reg   <= 3'b000;
            lane_reg     <= 2'b00;
            wdata_reg    <= 32'h0;
            merge_reg    <= 32'h0;
            rdata_reg    <= 32'h0;
            mem_addr_reg <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                funct3_reg   <= bus.funct3;
                lane_reg     <= bus.addr[1:0];
                wdata_reg    <= bus.wdata;
                mem_addr_reg <= {2'b00, bus.addr[31:2]};
                err_reg      <= req_err;
                if (req_err) begin
                    rdata_reg <= 32'h0;
                end
            end
            if (state_reg == LOAD) begin
                rdata_reg <= load_value;
            end
            if (state_reg == RMW_RD) begin
                merge_reg <= bus.mem_rd;
            end
        end
    end

    // Outputs decoded from state so reset drops mem_we without waiting for an edge
    always_comb begin
        bus.busy   = (state_reg != IDLE);
        bus.done   = (state_reg == RESP);
        bus.err    = (state_reg == RESP) && err_reg;
        bus.mem_we = (state_reg == WRITE) || (state_reg == RMW_WR);
        bus.mem_wd = 32'h0;
        case (state_reg)
            WRITE:   bus.mem_wd = wdata_reg;
            RMW_WR:  bus.mem_wd = merged;
            default: bus.mem_wd = 32'h0;
        endcase
    end

    assign bus.rdata    = rdata_reg;
    assign bus.mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed bench for load_store_unit against a byte-level
// reference model of the data memory and load/store semantics.
module tb_load_store_unit;

    localparam int MEM_WORDS = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] rdata_exp;
    logic [31:0] obs_rdata;
    int          errors = 0;
    int          checks = 0;
    int          txn    = 0;

    // Data memory: combinational read, write on the rising edge
    assign bus.mem_rd = (bus.mem_addr < 32'(MEM_WORDS)) ? mem[bus.mem_addr[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_addr < 32'(MEM_WORDS)))
            mem[bus.mem_addr[8:0]] <= bus.mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural model: works on byte offsets and sizes, updates ref_mem/rdata_exp
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int nwe, output logic e);
        int          sz;
        int          sh;
        logic        legal;
        logic [31:0] widx;
        logic [31:0] mask;
        logic [31:0] v;
        legal = w ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        widx  = a >> 2;
        e     = !legal || ((int'(a[1:0]) % sz) != 0) || (widx >= 32'(MEM_WORDS));
        if (e) begin
            lat = 1; nwe = 0; rdata_exp = 32'h0;
            return;
        end
        sh   = int'(a[1:0]) * 8;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        if (!w) begin
            v = (ref_mem[widx[8:0]] >> sh) & mask;
            if (!f3[2] && (sz < 4) && v[8*sz-1]) v = v | ~mask;
            rdata_exp = v;
            lat = 2; nwe = 0;
        end else begin
            ref_mem[widx[8:0]] = (ref_mem[widx[8:0]] & ~(mask << sh)) | ((d << sh) & (mask << sh));
            lat = (sz == 4) ? 2 : 3;
            nwe = 1;
        end
    endtask

    task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
        int          lat_exp, nwe_exp, lat_seen, nwe_seen, diff;
        logic        err_exp, err_seen;
        logic [31:0] rd_seen, addr_seen;
        model(w, f3, a, d, lat_exp, nwe_exp, err_exp);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        // Scramble request inputs: the unit must work from its latched copy
        bus.req = 1'b0; bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
        lat_seen = 0; nwe_seen = 0; err_seen = 1'b0; rd_seen = 32'h0; addr_seen = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_we) nwe_seen++;
            if (c == 1) addr_seen = bus.mem_addr;
            if (bus.done) begin
                lat_seen = c; err_seen = bus.err; rd_seen = bus.rdata;
                break;
            end
            if (!bus.busy) break;
        end
        diff = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("latency",  32'(lat_seen), 32'(lat_exp));
        check("err",      {31'h0, err_seen}, {31'h0, err_exp});
        check("rdata",    rd_seen, rdata_exp);
        check("mem_we_cycles", 32'(nwe_seen), 32'(nwe_exp));
        check("mem_addr", addr_seen, {2'b00, a[31:2]});
        check("mem_image_diff", 32'(diff), 32'h0);
        obs_rdata = rd_seen;
        txn++;
        $display("txn %0d we=%0b f3=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 txn, w, f3, a, d, rd_seen, err_seen, lat_seen);
    endtask

    // Reset asserted in RMW_RD (cyc=1) or RMW_WR (cyc=2) of an SB to 0x10
    task automatic reset_during_rmw(input int cyc);
        int diff;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h10; bus.wdata = 32'hA5;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        if (cyc == 2) begin
            @(posedge clk);
            #1;
            check("rmw_wr_we_before_reset", {31'h0, bus.mem_we}, 32'h1);
        end
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy",   {31'h0, bus.busy},   32'h0);
        check("rst_done",   {31'h0, bus.done},   32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        @(posedge clk);
        #1;
        diff = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("rst_mem_image_diff", 32'(diff), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rdata_exp = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        $display("reset during rmw cycle %0d: word4=%h", cyc, mem[4]);
    endtask

    // req held high: second load accepted only after the unit returns to IDLE
    task automatic hold_req_test();
        logic [5:0] busy_v, done_v;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h10; bus.wdata = 32'h0;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            busy_v[c] = bus.busy;
            done_v[c] = bus.done;
            if (c == 4) bus.req = 1'b0;
        end
        check("hold_busy_pattern", {26'h0, busy_v}, 32'h1B);
        check("hold_done_pattern", {26'h0, done_v}, 32'h12);
        check("hold_rdata", bus.rdata, 32'h1234_55EF);
        rdata_exp = 32'h1234_55EF;
        $display("hold req: busy=%b done=%b rdata=%h", busy_v, done_v, bus.rdata);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] widx;
        logic [31:0] a;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",     {31'h0, bus.busy},   32'h0);
        check("reset_done",     {31'h0, bus.done},   32'h0);
        check("reset_err",      {31'h0, bus.err},    32'h0);
        check("reset_mem_we",   {31'h0, bus.mem_we}, 32'h0);
        check("reset_rdata",    bus.rdata,    32'h0);
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        check("reset_mem_wd",   bus.mem_wd,   32'h0);
        rdata_exp = 32'h0;
        @(negedge clk);
        reset = 1'b0;

        // Directed walk through the documented cases
        do_access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        check("sw_word4", mem[4], 32'hDEAD_BEEF);
        do_access(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_0x10",  obs_rdata, 32'hDEAD_BEEF);
        do_access(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_0x13",  obs_rdata, 32'hFFFF_FFDE);
        do_access(1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_0x13", obs_rdata, 32'h0000_00DE);
        do_access(1'b0, 3'b001, 32'h12, 32'h0);
        check("lh_0x12",  obs_rdata, 32'hFFFF_DEAD);
        do_access(1'b0, 3'b101, 32'h10, 32'h0);
        check("lhu_0x10", obs_rdata, 32'h0000_BEEF);
        do_access(1'b1, 3'b000, 32'h11, 32'h0000_0055);
        check("sb_word4", mem[4], 32'hDEAD_55EF);
        do_access(1'b1, 3'b001, 32'h12, 32'h0000_1234);
        check("sh_word4", mem[4], 32'h1234_55EF);

        // Error cases, each preceded by a load so a cleared rdata is visible
        do_access(1'b0, 3'b010, 32'h11,  32'h0);
        check("err_lw_misaligned_rdata", obs_rdata, 32'h0);
        do_access(1'b0, 3'b010, 32'h10,  32'h0);
        do_access(1'b1, 3'b001, 32'h13,  32'hFFFF);
        check("err_sh_misaligned_rdata", obs_rdata, 32'h0);
        do_access(1'b0, 3'b010, 32'h10,  32'h0);
        do_access(1'b0, 3'b011, 32'h10,  32'h0);
        check("err_f3_011_rdata", obs_rdata, 32'h0);
        do_access(1'b0, 3'b010, 32'h10,  32'h0);
        do_access(1'b1, 3'b100, 32'h10,  32'h77);
        check("err_store_f3_100_rdata", obs_rdata, 32'h0);
        do_access(1'b0, 3'b010, 32'h10,  32'h0);
        do_access(1'b0, 3'b010, 32'h800, 32'h0);
        check("err_out_of_range_rdata", obs_rdata, 32'h0);
        do_access(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1111_2222);
        check("word4_after_errors", mem[4], 32'h1234_55EF);

        hold_req_test();

        reset_during_rmw(1);
        check("word4_after_rst_rmw_rd", mem[4], 32'h1234_55EF);
        reset_during_rmw(2);
        check("word4_after_rst_rmw_wr", mem[4], 32'h1234_55EF);
        do_access(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_after_reset", obs_rdata, 32'h1234_55EF);

        // Random traffic over a small window plus occasional out-of-range words
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) widx = 32'($urandom_range(MEM_WORDS, MEM_WORDS + 8));
            else                           widx = 32'($urandom_range(0, 15));
            a = {widx[29:0], 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
